// File: rtl/rotary_count_if.sv
// Handshake bundle between the encoder filter / register block and rotary_count_ctrl.
// The master side drives events and control; the slave side returns the position state.
interface rotary_count_if #(
    parameter int unsigned CNT_W = 8
);
    logic             rotary_event;
    logic             rotary_left;
    logic             enable;
    logic             wrap_mode;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             ack;
    logic [CNT_W-1:0] count;
    logic             changed;
    logic             last_left;
    logic             accel_active;

    modport master (
        output rotary_event, rotary_left, enable, wrap_mode, load, load_value, ack,
        input  count, changed, last_left, accel_active
    );

    modport slave (
        input  rotary_event, rotary_left, enable, wrap_mode, load, load_value, ack,
        output count, changed, last_left, accel_active
    );
endinterface

// File: rtl/rotary_count_ctrl.sv
// Turns rotary detent pulses into a bounded position count with saturate/wrap,
// direct load, speed-based acceleration and a sticky changed flag.
module rotary_count_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned CNT_MIN      = 0,
    parameter int unsigned CNT_MAX      = 255,
    parameter int unsigned STEP         = 1,
    parameter int unsigned ACCEL_STEP   = 4,
    parameter int unsigned ACCEL_WINDOW = 500000,
    parameter int unsigned ACCEL_THRESH = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    rotary_count_if.slave bus_io
);
    localparam int unsigned W1    = CNT_W + 1;
    localparam int unsigned GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam int unsigned RUN_W = $clog2(ACCEL_THRESH + 1);

    localparam logic [W1-1:0]    MIN_X   = W1'(CNT_MIN);
    localparam logic [W1-1:0]    MAX_X   = W1'(CNT_MAX);
    localparam logic [W1-1:0]    RANGE_X = W1'(CNT_MAX - CNT_MIN + 1);
    localparam logic [W1-1:0]    STEP_X  = W1'(STEP);
    localparam logic [W1-1:0]    ACCEL_X = W1'(ACCEL_STEP);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ACCEL_WINDOW);
    localparam logic [RUN_W:0]   RUN_THR = (RUN_W + 1)'(ACCEL_THRESH);

    typedef enum logic [0:0] {StSlow, StFast} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             changed_q, changed_d;
    logic             last_left_q, last_left_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic             accept;
    logic             is_fast;
    logic [W1-1:0]    cur, step, sum, ev_next, ld_ext, ld_next;
    logic [RUN_W:0]   run_inc;

    // One extra bit of headroom keeps sums and the left-side bound test alias-free.
    always_comb begin
        accept  = bus_io.rotary_event & bus_io.enable & ~bus_io.load;
        is_fast = (gap_q < GAP_MAX) && (bus_io.rotary_left == last_left_q);
        step    = (state_q == StFast) ? ACCEL_X : STEP_X;
        cur     = {1'b0, count_q};
        sum     = cur + step;
        ev_next = cur;
        if (!bus_io.rotary_left) begin
            if (sum > MAX_X) ev_next = bus_io.wrap_mode ? (sum - RANGE_X) : MAX_X;
            else             ev_next = sum;
        end else begin
            if (cur < MIN_X + step) ev_next = bus_io.wrap_mode ? (cur + RANGE_X - step) : MIN_X;
            else                    ev_next = cur - step;
        end
        ld_ext  = {1'b0, bus_io.load_value};
        if (ld_ext < MIN_X)      ld_next = MIN_X;
        else if (ld_ext > MAX_X) ld_next = MAX_X;
        else                     ld_next = ld_ext;
        run_inc = {1'b0, run_q} + (RUN_W + 1)'(1);
    end

    always_comb begin
        count_d     = count_q;
        changed_d   = changed_q;
        last_left_d = last_left_q;
        gap_d       = gap_q;
        run_d       = run_q;
        state_d     = state_q;

        if (bus_io.load) begin
            count_d = ld_next[CNT_W-1:0];
        end else if (accept) begin
            count_d     = ev_next[CNT_W-1:0];
            last_left_d = bus_io.rotary_left;
        end

        // A real count change beats a simultaneous ack.
        if (accept && (ev_next[CNT_W-1:0] != count_q)) changed_d = 1'b1;
        else if (bus_io.ack)                           changed_d = 1'b0;

        if (!bus_io.enable)         gap_d = GAP_MAX;
        else if (accept)            gap_d = '0;
        else if (gap_q < GAP_MAX)   gap_d = gap_q + GAP_W'(1);

        if (!bus_io.enable) begin
            state_d = StSlow;
            run_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                StSlow: begin
                    if (is_fast) begin
                        if (run_inc <= RUN_THR) run_d = run_inc[RUN_W-1:0];
                        if (run_inc >= RUN_THR) state_d = StFast;
                    end else begin
                        run_d = RUN_W'(1);
                    end
                end
                StFast: begin
                    if (!is_fast) begin
                        state_d = StSlow;
                        run_d   = RUN_W'(1);
                    end
                end
                default: state_d = StSlow;
            endcase
        end else if ((state_q == StFast) && (gap_q >= GAP_MAX)) begin
            state_d = StSlow;
            run_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StSlow;
            count_q     <= CNT_W'(CNT_MIN);
            changed_q   <= 1'b0;
            last_left_q <= 1'b0;
            gap_q       <= GAP_MAX;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            changed_q   <= changed_d;
            last_left_q <= last_left_d;
            gap_q       <= gap_d;
            run_q       <= run_d;
        end
    end

    assign bus_io.count        = count_q;
    assign bus_io.changed      = changed_q;
    assign bus_io.last_left    = last_left_q;
    assign bus_io.accel_active = (state_q == StFast);
endmodule

// File: tb/tb_rotary_count_ctrl.sv
// Scenario bench for rotary_count_ctrl: each task walks a step table, pushing the
// expected outputs before driving a step and popping them once the DUT has responded.
module tb_rotary_count_ctrl;
    localparam int unsigned CW    = 9;
    localparam int unsigned WIN   = 64;
    localparam int          SLOW  = 200;
    localparam int          FASTG = 10;

    localparam int KR = 0, KL = 1, KACK = 2, KLD = 3, KIDLE = 4, KLDEV = 5, KLACK = 6,
                   KDIS = 7, KEN = 8;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          changed;
        logic          last_left;
        logic          accel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rotary_count_if #(.CNT_W(CW)) bus ();

    rotary_count_ctrl #(
        .CNT_W(CW), .CNT_MIN(0), .CNT_MAX(255), .STEP(1), .ACCEL_STEP(4),
        .ACCEL_WINDOW(WIN), .ACCEL_THRESH(3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t e, o;

    function automatic exp_t mk(input int c, input logic ch, input logic l, input logic a);
        mk = {CW'(c), ch, l, a};
    endfunction

    function automatic exp_t obs();
        obs = {bus.count, bus.changed, bus.last_left, bus.accel_active};
    endfunction

    function automatic string fmt(input exp_t x);
        fmt = $sformatf("count=%0d changed=%b last_left=%b accel=%b",
                        x.count, x.changed, x.last_left, x.accel);
    endfunction

    task automatic pulse(input logic left, input int gap);
        repeat (gap) @(negedge clk);
        bus.rotary_left  = left;
        bus.rotary_event = 1'b1;
        @(negedge clk);
        bus.rotary_event = 1'b0;
    endtask

    // Drives one table step; returns at the negedge after the sampling edge.
    task automatic step(input int k, input int v);
        case (k)
            KR, KL: pulse(k == KL, v);
            KACK:   begin bus.ack = 1'b1; @(negedge clk); bus.ack = 1'b0; end
            KLD:    begin
                bus.load = 1'b1; bus.load_value = CW'(v);
                @(negedge clk); bus.load = 1'b0;
            end
            KIDLE:  repeat (v) @(negedge clk);
            KLDEV:  begin
                bus.load = 1'b1; bus.load_value = CW'(v);
                bus.rotary_event = 1'b1; bus.rotary_left = 1'b0;
                @(negedge clk); bus.load = 1'b0; bus.rotary_event = 1'b0;
            end
            KLACK:  begin
                repeat (v) @(negedge clk);
                bus.rotary_event = 1'b1; bus.rotary_left = 1'b1; bus.ack = 1'b1;
                @(negedge clk); bus.rotary_event = 1'b0; bus.ack = 1'b0;
            end
            KDIS:   begin bus.enable = 1'b0; @(negedge clk); end
            KEN:    begin bus.enable = 1'b1; @(negedge clk); end
            default: @(negedge clk);
        endcase
    endtask

    task automatic test_reset();
        bus.rotary_event = 1'b0; bus.rotary_left = 1'b0; bus.enable = 1'b1;
        bus.wrap_mode = 1'b0; bus.load = 1'b0; bus.load_value = '0; bus.ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 0));
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL reset_held: got %s, want %s", fmt(o), fmt(e));
        end
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL reset_release: got %s, want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_basic();
        int   k[4]  = '{KR, KR, KR, KACK};
        int   v[4]  = '{SLOW, SLOW, SLOW, 0};
        exp_t x[4]  = '{mk(1, 1, 0, 0), mk(2, 1, 0, 0), mk(3, 1, 0, 0), mk(3, 0, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL basic[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_saturate();
        int   k[6] = '{KLD, KR, KACK, KR, KR, KL};
        int   v[6] = '{254, SLOW, 0, SLOW, SLOW, SLOW};
        exp_t x[6] = '{mk(254, 0, 0, 0), mk(255, 1, 0, 0), mk(255, 0, 0, 0),
                       mk(255, 0, 0, 0), mk(255, 0, 0, 0), mk(254, 1, 1, 0)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL saturate[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        int   k[5] = '{KACK, KLD, KL, KL, KR};
        int   v[5] = '{0, 1, SLOW, SLOW, SLOW};
        exp_t x[5] = '{mk(254, 0, 1, 0), mk(1, 0, 1, 0), mk(0, 1, 1, 0),
                       mk(255, 1, 1, 0), mk(0, 1, 0, 0)};
        bus.wrap_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
        bus.wrap_mode = 1'b0;
    endtask

    task automatic test_accel();
        int   k[10] = '{KLD, KACK, KR, KR, KR, KR, KR, KR, KIDLE, KR};
        int   v[10] = '{10, 0, SLOW, FASTG, FASTG, FASTG, FASTG, FASTG, WIN + 8, 0};
        exp_t x[10] = '{mk(10, 1, 0, 0), mk(10, 0, 0, 0), mk(11, 1, 0, 0), mk(12, 1, 0, 0),
                        mk(13, 1, 0, 1), mk(17, 1, 0, 1), mk(21, 1, 0, 1), mk(25, 1, 0, 1),
                        mk(25, 1, 0, 0), mk(26, 1, 0, 0)};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL accel[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_priority();
        int   k[3] = '{KACK, KLDEV, KLACK};
        int   v[3] = '{0, 300, SLOW};
        exp_t x[3] = '{mk(26, 0, 0, 0), mk(255, 0, 0, 0), mk(254, 1, 1, 0)};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL priority[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        int   k[5] = '{KLD, KR, KR, KR, KLD};
        int   v[5] = '{50, SLOW, FASTG, FASTG, 100};
        exp_t x[5] = '{mk(50, 1, 1, 0), mk(51, 1, 0, 0), mk(52, 1, 0, 0),
                       mk(53, 1, 0, 1), mk(100, 1, 0, 1)};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL async_pre[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
        // Assert reset between edges and sample before the next rising edge.
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL async_reset: got %s, want %s", fmt(o), fmt(e));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_enable();
        int   k[8] = '{KR, KR, KR, KDIS, KR, KR, KEN, KR};
        int   v[8] = '{SLOW, FASTG, FASTG, 0, FASTG, FASTG, 0, FASTG};
        exp_t x[8] = '{mk(1, 1, 0, 0), mk(2, 1, 0, 0), mk(3, 1, 0, 1), mk(3, 1, 0, 0),
                       mk(3, 1, 0, 0), mk(3, 1, 0, 0), mk(3, 1, 0, 0), mk(4, 1, 0, 0)};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(x[i]);
            step(k[i], v[i]);
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL enable[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_wrap();
        test_accel();
        test_priority();
        test_async_reset();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rotary_count_ctrl.md
Name: rotary_count_ctrl

Overview:
Controller that turns the one-cycle rotary_event/rotary_left pulses from the rotary encoder filter into a bounded position count for software.
- Supports saturate or wrap mode, direct load and speed-based acceleration.
- Raises a sticky change flag with an acknowledge handshake, so the processor interface can poll or take an interrupt.
- Sits between the encoder filter and the peripheral register interface.

Parameters:
CNT_W, 8, width of count and load_value
CNT_MIN, 0, lowest legal count (unsigned)
CNT_MAX, 255, highest legal count; CNT_MIN < CNT_MAX < 2**CNT_W
STEP, 1, increment per event in slow mode
ACCEL_STEP, 4, increment per event in fast mode; STEP and ACCEL_STEP must each be <= CNT_MAX-CNT_MIN+1
ACCEL_WINDOW, 500000, max clk cycles between events to count as "fast"
ACCEL_THRESH, 3, consecutive fast same-direction events needed to enter fast mode

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rotary_event  in  1  one-cycle pulse per detent, from encoder filter
rotary_left  in  1  direction for the event: 1 = left/decrement, 0 = right/increment
enable  in  1  1 = process events; 0 = ignore events, force slow mode
wrap_mode  in  1  1 = wrap at bounds, 0 = saturate at bounds
load  in  1  one-cycle strobe: count <= clamp(load_value)
load_value  in  CNT_W  value for load
ack  in  1  clears changed
count  out  CNT_W  current position
changed  out  1  sticky: count modified by an event since last ack
last_left  out  1  direction of most recent accepted event
accel_active  out  1  1 while in FAST state

Behaviour:
- Reset (async, immediate): count=CNT_MIN, changed=0, last_left=0, accel_active=0, gap counter=ACCEL_WINDOW (saturated), run counter=0, FSM=SLOW.
- Latency: an event sampled on edge N updates count, changed and last_left on that same edge, so they are visible in the following cycle. There is no further pipelining.
- Event acceptance: an event is accepted when rotary_event=1, enable=1 and load=0.

Step and count update:
- step = ACCEL_STEP if FSM=FAST at the sampling edge, else STEP. The FSM transition caused by the same event applies from the next event.
- Right event, saturate mode: count = min(count+step, CNT_MAX).
- Right event, wrap mode: if count+step > CNT_MAX, count = count+step-(CNT_MAX-CNT_MIN+1).
- Left event, saturate mode: count = max(count-step, CNT_MIN).
- Left event, wrap mode: if count-step < CNT_MIN, count = count-step+(CNT_MAX-CNT_MIN+1).
- Intermediate arithmetic is CNT_W+1 bits and signed-safe, so there is no overflow aliasing.

Load:
- load has priority over a simultaneous event; that event is dropped.
- count = CNT_MIN if load_value < CNT_MIN; CNT_MAX if load_value > CNT_MAX; else load_value.
- Load does not set changed and does not alter the FSM.

changed flag:
- Set when an accepted event produces new count != old count. A saturated no-op does not set it.
- Cleared by ack.
- Set and ack in the same cycle: set wins and changed stays 1.

last_left: updated on every accepted event, including saturated no-ops.

Gap counter:
- Resets to 0 on every accepted event.
- Otherwise increments each cycle, saturating at ACCEL_WINDOW.
- An event is "fast" if gap < ACCEL_WINDOW and rotary_left == last_left.

Accel FSM (SLOW/FAST), transitions on accepted events:
- SLOW, fast event: run += 1. If run+1 >= ACCEL_THRESH, go to FAST.
- SLOW, non-fast event: run = 1.
- FAST, fast event: stay in FAST.
- FAST, non-fast event (direction reversal or timeout): go to SLOW with run = 1.
- FAST, gap reaches ACCEL_WINDOW with no event: go to SLOW with run = 0.
- enable=0: go to SLOW, run = 0, gap saturated. count and changed are held.
- accel_active = (FSM == FAST).

Test Plan:
- Reset then 3 right events spaced 1,000,000 cycles (defaults) -> count 0,1,2,3 one cycle after each pulse; changed=1 after first; ack -> changed=0 next cycle.
- Saturate: load 254, then 3 right events spaced slow -> count 255,255,255; changed set only by first; left event -> 254, last_left=1.
- Wrap: wrap_mode=1, load 1, 2 slow left events -> count 0 then 255; right event -> 0.
- Accel: 6 right events spaced 100 cycles from count 10 -> counts 11,12,13,17,21,25 (accel_active=1 after 3rd event); then idle 500000 cycles -> accel_active=0; next event +1.
- Priority/corner: load=1 with load_value=300 (CNT_W=9, CNT_MAX=255) and rotary_event same cycle -> count=255, event dropped, changed unchanged; event with ack in same cycle -> changed=1.
- Async reset asserted mid-cycle during FAST with count=100 -> outputs go to reset values immediately without waiting for a clk edge; enable=0 during fast events -> count frozen, accel_active=0.
